// File: rtl/fwd_hazard_ctrl_pkg.sv
// rtl/fwd_hazard_ctrl_pkg.sv - shared select codes and stage record for forwarding/hazard control
package fwd_hazard_ctrl_pkg;

    localparam int REG_ADDR_W_DEF = 5;

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_EX  = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;
    localparam logic [1:0] SEL_MUL = 2'd3;

    typedef struct packed {
        logic                      vld;
        logic [REG_ADDR_W_DEF-1:0] rd;
        logic                      regw;
        logic                      load;
        logic                      mult;
    } stage_t;

endpackage

// File: rtl/fwd_sel_cmp.sv
// rtl/fwd_sel_cmp.sv - per-operand producer match and youngest-first forwarding select
module fwd_sel_cmp
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  ex_vld,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_regw,
    input  logic                  ex_load,
    input  logic                  ex_mult,
    input  logic                  mem_vld,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_regw,
    output logic [1:0]            sel,
    output logic                  load_use
);

    logic ex_hit;
    logic mem_hit;

    // x0 is hardwired zero, so it never matches a producer
    assign ex_hit  = ex_vld  && ex_regw  && (ex_rd  == rs) && (rs != '0);
    assign mem_hit = mem_vld && mem_regw && (mem_rd == rs) && (rs != '0);

    always_comb begin
        sel      = SEL_RF;
        load_use = 1'b0;
        if (ex_hit) begin
            if (ex_mult) begin
                sel = SEL_MUL;
            end else if (ex_load) begin
                load_use = 1'b1;
            end else begin
                sel = SEL_EX;
            end
        end else if (mem_hit) begin
            sel = SEL_MEM;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - operand forwarding selects and load-use/multiplier stall control
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int MULT_LAT   = 4,
    parameter int CNT_W      = $clog2(MULT_LAT) + 1
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_is_mult,
    input  logic                  flush,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b,
    output logic                  stall,
    output logic                  mult_busy
);

    logic                  ex_vld;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_regw;
    logic                  ex_load;
    logic                  ex_mult;
    logic                  mem_vld;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  mem_regw;
    logic [CNT_W-1:0]      mult_cnt;

    logic                  load_use_a;
    logic                  load_use_b;
    logic                  accept;

    fwd_sel_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_a (
        .rs       (id_rs1),
        .ex_vld   (ex_vld),
        .ex_rd    (ex_rd),
        .ex_regw  (ex_regw),
        .ex_load  (ex_load),
        .ex_mult  (ex_mult),
        .mem_vld  (mem_vld),
        .mem_rd   (mem_rd),
        .mem_regw (mem_regw),
        .sel      (fwd_sel_a),
        .load_use (load_use_a)
    );

    fwd_sel_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_b (
        .rs       (id_rs2),
        .ex_vld   (ex_vld),
        .ex_rd    (ex_rd),
        .ex_regw  (ex_regw),
        .ex_load  (ex_load),
        .ex_mult  (ex_mult),
        .mem_vld  (mem_vld),
        .mem_rd   (mem_rd),
        .mem_regw (mem_regw),
        .sel      (fwd_sel_b),
        .load_use (load_use_b)
    );

    assign mult_busy = (mult_cnt != '0);
    // A flushed ID instruction is dead, so its load-use hazard is irrelevant
    assign stall  = id_valid && (mult_busy || (!flush && (load_use_a || load_use_b)));
    assign accept = id_valid && !stall && !flush;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ex_vld   <= 1'b0;
            ex_rd    <= '0;
            ex_regw  <= 1'b0;
            ex_load  <= 1'b0;
            ex_mult  <= 1'b0;
            mem_vld  <= 1'b0;
            mem_rd   <= '0;
            mem_regw <= 1'b0;
            mult_cnt <= '0;
        end else if (mult_busy) begin
            // Multiply holds EX; MEM drains into a bubble each cycle
            mult_cnt <= mult_cnt - CNT_W'(1);
            mem_vld  <= 1'b0;
            mem_rd   <= '0;
            mem_regw <= 1'b0;
        end else begin
            mem_vld  <= ex_vld;
            mem_rd   <= ex_rd;
            mem_regw <= ex_regw;
            if (accept) begin
                ex_vld   <= 1'b1;
                ex_rd    <= id_rd;
                ex_regw  <= id_reg_write;
                ex_load  <= id_mem_read;
                ex_mult  <= id_is_mult;
                mult_cnt <= id_is_mult ? CNT_W'(MULT_LAT - 1) : '0;
            end else begin
                ex_vld   <= 1'b0;
                ex_rd    <= '0;
                ex_regw  <= 1'b0;
                ex_load  <= 1'b0;
                ex_mult  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - randomized and scenario checks against an in-flight instruction model
module tb_fwd_hazard_ctrl;

    localparam int RW = 5;
    localparam int ML = 4;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic          id_valid = 1'b0;
    logic [RW-1:0] id_rs1 = '0;
    logic [RW-1:0] id_rs2 = '0;
    logic [RW-1:0] id_rd = '0;
    logic          id_reg_write = 1'b0;
    logic          id_mem_read = 1'b0;
    logic          id_is_mult = 1'b0;
    logic          flush = 1'b0;
    logic [1:0]    fwd_sel_a;
    logic [1:0]    fwd_sel_b;
    logic          stall;
    logic          mult_busy;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.REG_ADDR_W(RW), .MULT_LAT(ML)) dut (
        .clk          (clk),
        .arst         (arst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .id_is_mult   (id_is_mult),
        .flush        (flush),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .stall        (stall),
        .mult_busy    (mult_busy)
    );

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        bit vld;
        int rd;
        bit writes;
        bit load;
        bit mult;
    } ins_t;

    // flight[0] is the instruction in EX, flight[1] the one in MEM
    ins_t flight[2];
    int   ex_cycles_left;

    function automatic ins_t empty_slot();
        ins_t e;
        e.vld = 0; e.rd = 0; e.writes = 0; e.load = 0; e.mult = 0;
        return e;
    endfunction

    task automatic model_reset();
        flight[0] = empty_slot();
        flight[1] = empty_slot();
        ex_cycles_left = 0;
    endtask

    function automatic int want_sel(input int rs, output bit lu);
        lu = 0;
        for (int s = 0; s < 2; s++) begin
            if (flight[s].vld && flight[s].writes && flight[s].rd == rs && rs != 0) begin
                if (s == 1) return 2;
                if (flight[s].mult) return 3;
                if (flight[s].load) begin
                    lu = 1;
                    return 0;
                end
                return 1;
            end
        end
        return 0;
    endfunction

    task automatic model_outputs(output int sa, output int sb, output bit st, output bit mb);
        bit lua, lub;
        sa = want_sel(int'(id_rs1), lua);
        sb = want_sel(int'(id_rs2), lub);
        mb = (ex_cycles_left > 0);
        st = id_valid && (mb || (!flush && (lua || lub)));
    endtask

    task automatic drive(input bit v, input int rs1, input int rs2, input int rd,
                         input bit rw, input bit ld, input bit ml, input bit fl);
        id_valid     = v;
        id_rs1       = RW'(rs1);
        id_rs2       = RW'(rs2);
        id_rd        = RW'(rd);
        id_reg_write = rw;
        id_mem_read  = ld;
        id_is_mult   = ml;
        flush        = fl;
        #2;
    endtask

    task automatic tick();
        int sa, sb;
        bit st, mb;
        model_outputs(sa, sb, st, mb);
        if (ex_cycles_left > 0) begin
            ex_cycles_left--;
            flight[1] = empty_slot();
        end else begin
            flight[1] = flight[0];
            flight[0] = empty_slot();
            if (id_valid && !st && !flush) begin
                flight[0].vld    = 1;
                flight[0].rd     = int'(id_rd);
                flight[0].writes = id_reg_write;
                flight[0].load   = id_mem_read;
                flight[0].mult   = id_is_mult;
                if (id_is_mult) ex_cycles_left = ML - 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        arst = 1'b1;
        drive(1, 5, 5, 6, 1, 0, 0, 0);
        vectors++; if (fwd_sel_a !== 2'd0) begin errors++; $display("FAIL reset_sel_a got=%0d want=0", fwd_sel_a); end
        vectors++; if (fwd_sel_b !== 2'd0) begin errors++; $display("FAIL reset_sel_b got=%0d want=0", fwd_sel_b); end
        vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b want=0", stall); end
        vectors++; if (mult_busy !== 1'b0) begin errors++; $display("FAIL reset_mult_busy got=%0b want=0", mult_busy); end
        @(posedge clk);
        #1;
        arst = 1'b0;
        model_reset();
        idle(1);
    endtask

    task automatic test_alu_back_to_back();
        drive(1, 1, 2, 5, 1, 0, 0, 0);
        tick();
        drive(1, 5, 1, 6, 1, 0, 0, 0);
        vectors++; if (fwd_sel_a !== 2'd1) begin errors++; $display("FAIL alu_ex_sel_a got=%0d want=1", fwd_sel_a); end
        vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_ex_stall got=%0b want=0", stall); end
        tick();
        drive(1, 2, 5, 8, 1, 0, 0, 0);
        vectors++; if (fwd_sel_b !== 2'd2) begin errors++; $display("FAIL alu_mem_sel_b got=%0d want=2", fwd_sel_b); end
        tick();
        idle(3);
    endtask

    task automatic test_load_use();
        drive(1, 1, 2, 7, 1, 1, 0, 0);
        tick();
        drive(1, 7, 1, 9, 1, 0, 0, 0);
        vectors++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%0b want=1", stall); end
        vectors++; if (fwd_sel_a !== 2'd0) begin errors++; $display("FAIL lu_sel_a got=%0d want=0", fwd_sel_a); end
        tick();
        vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_release_stall got=%0b want=0", stall); end
        vectors++; if (fwd_sel_a !== 2'd2) begin errors++; $display("FAIL lu_mem_sel_a got=%0d want=2", fwd_sel_a); end
        tick();
        idle(3);
    endtask

    task automatic test_mult();
        drive(1, 1, 2, 3, 1, 0, 1, 0);
        tick();
        drive(1, 1, 3, 9, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            vectors++; if (stall !== 1'b1) begin errors++; $display("FAIL mul_stall cyc=%0d got=%0b want=1", i, stall); end
            vectors++; if (mult_busy !== 1'b1) begin errors++; $display("FAIL mul_busy cyc=%0d got=%0b want=1", i, mult_busy); end
            tick();
        end
        vectors++; if (fwd_sel_b !== 2'd3) begin errors++; $display("FAIL mul_sel_b got=%0d want=3", fwd_sel_b); end
        vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL mul_final_stall got=%0b want=0", stall); end
        vectors++; if (mult_busy !== 1'b0) begin errors++; $display("FAIL mul_final_busy got=%0b want=0", mult_busy); end
        tick();
        drive(1, 3, 1, 10, 1, 0, 0, 0);
        vectors++; if (fwd_sel_a !== 2'd2) begin errors++; $display("FAIL mul_mem_sel_a got=%0d want=2", fwd_sel_a); end
        tick();
        idle(3);
    endtask

    task automatic test_filter();
        drive(1, 1, 1, 4, 0, 0, 0, 0);
        tick();
        drive(1, 1, 1, 0, 1, 0, 0, 0);
        tick();
        drive(1, 0, 4, 11, 1, 0, 0, 0);
        vectors++; if (fwd_sel_a !== 2'd0) begin errors++; $display("FAIL x0_sel_a got=%0d want=0", fwd_sel_a); end
        vectors++; if (fwd_sel_b !== 2'd0) begin errors++; $display("FAIL nowrite_sel_b got=%0d want=0", fwd_sel_b); end
        vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL filter_stall got=%0b want=0", stall); end
        tick();
        idle(3);
    endtask

    task automatic test_flush();
        drive(1, 1, 2, 7, 1, 1, 0, 0);
        tick();
        drive(1, 7, 7, 12, 1, 0, 0, 1);
        vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_lu_stall got=%0b want=0", stall); end
        tick();
        drive(1, 12, 7, 13, 1, 0, 0, 0);
        vectors++; if (fwd_sel_a !== 2'd0) begin errors++; $display("FAIL flush_bubble_sel_a got=%0d want=0", fwd_sel_a); end
        vectors++; if (fwd_sel_b !== 2'd2) begin errors++; $display("FAIL flush_mem_sel_b got=%0d want=2", fwd_sel_b); end
        tick();
        idle(3);
        drive(1, 1, 2, 3, 1, 0, 1, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 3, 1, 14, 1, 0, 0, 1);
            vectors++; if (mult_busy !== (i < 3)) begin errors++; $display("FAIL flush_mul_busy cyc=%0d got=%0b want=%0b", i, mult_busy, i < 3); end
            vectors++; if (stall !== (i < 3)) begin errors++; $display("FAIL flush_mul_stall cyc=%0d got=%0b want=%0b", i, stall, i < 3); end
            tick();
        end
        idle(3);
    endtask

    task automatic test_reset_mid_mult();
        drive(1, 1, 2, 3, 1, 0, 1, 0);
        tick();
        idle(1);
        drive(1, 1, 3, 15, 1, 0, 0, 0);
        vectors++; if (stall !== 1'b1) begin errors++; $display("FAIL rstmul_pre_stall got=%0b want=1", stall); end
        #1;
        arst = 1'b1;
        #1;
        vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL rstmul_stall got=%0b want=0", stall); end
        vectors++; if (mult_busy !== 1'b0) begin errors++; $display("FAIL rstmul_busy got=%0b want=0", mult_busy); end
        @(posedge clk);
        #1;
        arst = 1'b0;
        model_reset();
        drive(1, 1, 3, 15, 1, 0, 0, 0);
        vectors++; if (fwd_sel_b !== 2'd0) begin errors++; $display("FAIL rstmul_sel_b got=%0d want=0", fwd_sel_b); end
        tick();
        idle(3);
    endtask

    task automatic test_random();
        int sa, sb;
        bit st, mb;
        int kind;
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 7);
            drive($urandom_range(0, 4) != 0,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3) != 0, kind < 2, kind == 2,
                  $urandom_range(0, 9) == 0);
            model_outputs(sa, sb, st, mb);
            vectors++; if (fwd_sel_a !== 2'(sa)) begin errors++; $display("FAIL rnd_sel_a n=%0d got=%0d want=%0d", n, fwd_sel_a, sa); end
            vectors++; if (fwd_sel_b !== 2'(sb)) begin errors++; $display("FAIL rnd_sel_b n=%0d got=%0d want=%0d", n, fwd_sel_b, sb); end
            vectors++; if (stall !== st) begin errors++; $display("FAIL rnd_stall n=%0d got=%0b want=%0b", n, stall, st); end
            vectors++; if (mult_busy !== mb) begin errors++; $display("FAIL rnd_busy n=%0d got=%0b want=%0b", n, mult_busy, mb); end
            tick();
        end
    endtask

    initial begin
        model_reset();
        #1;
        test_reset();
        test_alu_back_to_back();
        test_load_use();
        test_mult();
        test_filter();
        test_flush();
        test_reset_mid_mult();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
